// File: rtl/counting_pkg.sv
// Shared symbol constants and state encoding for the framed 2-bit symbol
// emitter and its matching counter/detector.
package counting_pkg;

  localparam logic [1:0] SYM_IDLE = 2'd0;
  localparam logic [1:0] SYM_HEAD = 2'd1;
  localparam logic [1:0] SYM_BODY = 2'd2;
  localparam logic [1:0] SYM_TAIL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_BODY = 3'd2,
    ST_TAIL = 3'd3,
    ST_FIN  = 3'd4
  } emit_state_t;

  function automatic logic [1:0] state_sym(input emit_state_t s, input logic [1:0] idle_sym);
    logic [1:0] sym;
    case (s)
      ST_HEAD: sym = SYM_HEAD;
      ST_BODY: sym = SYM_BODY;
      ST_TAIL: sym = SYM_TAIL;
      default: sym = idle_sym;
    endcase
    return sym;
  endfunction

  function automatic logic state_valid(input emit_state_t s);
    return (s == ST_HEAD) || (s == ST_BODY) || (s == ST_TAIL);
  endfunction

endpackage

// File: rtl/seq_rep_counter.sv
// Loadable down-counter holding the number of body symbols still to emit.
module seq_rep_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] value,
  output logic          is_zero,
  output logic          is_one
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - CW'(1);
    end
  end

  assign is_zero = (value == '0);
  assign is_one  = (value == CW'(1));

endmodule

// File: rtl/seq_emitter.sv
// Framed symbol generator: emits 1, N copies of 2, then 3 over a valid/ready
// handshake, pulses done afterwards and counts completed frames.
module seq_emitter
  import counting_pkg::*;
#(
  parameter int         CW       = 4,
  parameter logic [1:0] IDLE_SYM = SYM_IDLE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic [1:0]    num,
  output logic          num_valid,
  input  logic          num_ready,
  output logic          busy,
  output logic          done,
  output logic [7:0]    frames
);

  emit_state_t state, next_state;
  logic        accept;
  logic        rem_load, rem_dec, rem_zero, rem_one;
  logic [CW-1:0] rem;

  assign accept = num_valid & num_ready;

  seq_rep_counter #(.CW(CW)) u_rem (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (rem_load),
    .dec     (rem_dec),
    .load_val(cnt),
    .value   (rem),
    .is_zero (rem_zero),
    .is_one  (rem_one)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The state only advances on accept, so the symbol decoded from it holds
  // steady for as long as the consumer stalls.
  always_comb begin
    next_state = state;
    rem_load   = 1'b0;
    rem_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          rem_load   = 1'b1;
          next_state = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (accept) begin
          next_state = rem_zero ? ST_TAIL : ST_BODY;
        end
      end
      ST_BODY: begin
        if (accept) begin
          rem_dec = 1'b1;
          if (rem_one) begin
            next_state = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        if (accept) begin
          next_state = ST_FIN;
        end
      end
      ST_FIN:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num       <= IDLE_SYM;
      num_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frames    <= 8'd0;
    end else begin
      num       <= state_sym(next_state, IDLE_SYM);
      num_valid <= state_valid(next_state);
      busy      <= (next_state != ST_IDLE);
      done      <= (next_state == ST_FIN);
      if (state == ST_FIN) begin
        frames <= frames + 8'd1;
      end
    end
  end

endmodule

// File: doc/seq_emitter.md
Name: seq_emitter

Overview:
- Stimulus-side counterpart of the 2-bit symbol counter/detector. It generates a framed 2-bit symbol stream: one 1, then N copies of 2, then one 3.
- Its output drives the detector's num input directly, so on-chip self-test needs no hand-written stimulus.
- Output uses a valid/ready handshake; frames are requested by a start pulse carrying N.

Parameters:
- CW, 4, width of the repeat count N and of the internal repeat counter.
- IDLE_SYM, 0, 2-bit symbol driven on num while no symbol is valid.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  frame request; sampled only in IDLE.
- cnt  input  CW  number of 2-symbols in the frame; captured with start.
- num  output  2  current symbol.
- num_valid  output  1  num holds a frame symbol.
- num_ready  input  1  consumer accepts num this cycle.
- busy  output  1  a frame is in progress (not IDLE).
- done  output  1  one-cycle pulse after the 3-symbol is accepted.
- frames  output  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset: clock and reset are as decided: one clock, clk; reset rst_n is asynchronous and active-low.
  - While rst_n=0 and on its release: state=IDLE, num=IDLE_SYM, num_valid=0, busy=0, done=0, frames=0, repeat counter=0.
  - Asserting rst_n mid-frame abandons the frame immediately. No done pulse and no frames increment.
- All outputs are registered. A symbol is transferred on a rising edge where num_valid=1 and num_ready=1 ("accept").
- States are IDLE, HEAD, BODY, TAIL, FIN.
  - IDLE: num_valid=0. On start=1, latch rem<=cnt and go to HEAD. The first symbol appears the cycle after start.
  - HEAD: num=1, num_valid=1.
    - On accept: if rem==0 go to TAIL, else go to BODY.
    - Without accept: hold.
  - BODY: num=2, num_valid=1.
    - On accept: rem<=rem-1. If rem==1 go to TAIL, else stay in BODY.
    - Without accept: rem and num hold.
  - TAIL: num=3, num_valid=1. On accept go to FIN.
  - FIN: num_valid=0, done=1 for exactly one cycle, frames<=frames+1. The next cycle is IDLE.
- busy=1 in HEAD, BODY, TAIL and FIN.
- Holding rule: once num_valid=1, num must not change until it is accepted.
- start while busy is ignored and not queued. The cnt value used for a frame is the one captured at start; later cnt changes have no effect.
- cnt=0 gives the two-symbol frame 1,3. cnt=2^CW-1 gives 2^CW-1 twos; the counter never wraps.
- Throughput:
  - With num_ready held at 1, a frame takes N+2 cycles of valid symbols, then 1 FIN cycle, then IDLE.
  - The minimum spacing between start samples is N+4 cycles.
  - start held high continuously launches back-to-back frames, each separated by the FIN and IDLE cycles.
- num=IDLE_SYM whenever num_valid=0.

Decomposition:
- Shared package (counting_pkg): symbol constants SYM_HEAD=2'd1, SYM_BODY=2'd2, SYM_TAIL=2'd3, SYM_IDLE=2'd0, and the state encoding. The detector uses the same symbol constants.
- One natural sub-module: seq_rep_counter. It is a loadable down-counter of width CW with load, dec and is_zero/is_one outputs, used for rem.
- Everything else is a single FSM plus output registers.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles while driving start=1.
   -> num=0, num_valid=0, busy=0, frames=0.
   After release with start=0, no activity.
2. Basic frame: start with cnt=2, num_ready=1.
   -> accepted sequence 1,2,2,3 on 4 consecutive cycles, beginning the cycle after start.
   -> done pulses once, then frames=1, busy falls 6 cycles after start.
3. cnt=0 and maximum: cnt=0 -> sequence 1,3.
   cnt=15 (CW=4) -> 1, fifteen 2s, 3; frames increments by exactly 1 per frame.
4. Backpressure: cnt=3 with num_ready toggling 1,0,0,1,0,1,1,1.
   -> num is stable while not ready; the accepted stream is exactly 1,2,2,2,3; no symbol is duplicated or lost.
5. Ignored start / reset mid-frame:
   - start pulsed during BODY -> no second frame.
   - rst_n pulsed low during BODY -> outputs return to reset values asynchronously, done never pulses, frames unchanged.
6. Loopback: connect num to the detector input, gated by num_valid&num_ready, and run 10 random-cnt frames.
   -> the detector's ans asserts once per frame, and frames=10.
